// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared types and constants for the UART boot wrapper.
//   rx_state_e     - receiver FSM states
//   SENTINEL_WORD  - word that terminates a program load without being stored
//   clks_per_bit() - clock cycles per UART bit (integer division)
package uart_boot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam logic [31:0] SENTINEL_WORD = 32'hFFFF_FFFF;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_boot_wrapper_uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchronizer.
//   clk, rst        - clock, async active-high reset
//   uart_rxd        - serial line (idle high, asynchronous)
//   uart_rx_en      - receive enable; low aborts any frame in progress
//   uart_rx_break   - one-cycle pulse: stop bit low with all-zero data
//   uart_rx_valid   - one-cycle pulse: good frame received
//   uart_rx_data    - last received byte, loaded at the bit-7 sample
module uart_rx
    import uart_boot_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic       uart_rx_break,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rxd_meta, rxd_sync, rxd_prev;
    logic          fall;
    rx_state_e     state, state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          shift_en, load_data, set_valid, set_break, cnt_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall = rxd_prev & ~rxd_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        load_data  = 1'b0;
        set_valid  = 1'b0;
        set_break  = 1'b0;
        case (state)
            IDLE:  if (fall) state_next = START;
            START: if (baud_cnt == HALF_END) state_next = rxd_sync ? IDLE : DATA;
            DATA: begin
                if (baud_cnt == FULL_END) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        load_data  = 1'b1;
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == FULL_END) begin
                    if (rxd_sync)                   set_valid = 1'b1;
                    else if (uart_rx_data == 8'h00) set_break = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!uart_rx_en) begin
            state_next = IDLE;
            shift_en   = 1'b0;
            load_data  = 1'b0;
            set_valid  = 1'b0;
            set_break  = 1'b0;
        end
        // Counter restarts on every state change and after each data sample,
        // so each sample point is measured from the previous one.
        cnt_clr = (state == IDLE) || (state_next != state) || shift_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            baud_cnt      <= cnt_clr ? '0 : baud_cnt + CW'(1);
            uart_rx_valid <= set_valid;
            uart_rx_break <= set_break;
            if (state == IDLE) bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;
            if (shift_en)  shreg        <= {rxd_sync, shreg[7:1]};
            if (load_data) uart_rx_data <= {rxd_sync, shreg[7:1]};
        end
    end

endmodule

// File: rtl/uart_boot_wrapper.sv
// uart_boot_wrapper: loads a program image received over UART into imem as
// 32-bit little-endian words, then passes the roof sensor through to the
// actuator output.
//   clk, rst                    - clock, async active-high reset
//   uart_rxd, uart_rx_en        - UART line and receive enable
//   uart_rx_break/valid/data    - receiver status and last byte
//   input_gpio_pins             - roof sensor (asynchronous)
//   output_gpio_pins            - roof actuator (0 until load completes)
//   write_done                  - sticky: program load finished
module uart_boot_wrapper
    import uart_boot_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BIT_RATE   = 9600,
    parameter int unsigned IMEM_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic       uart_rx_break,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data,
    input  logic       input_gpio_pins,
    output logic       output_gpio_pins,
    output logic       write_done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned AW           = $clog2(IMEM_DEPTH);

    logic [31:0]   imem [IMEM_DEPTH];
    logic [1:0]    byte_idx;
    logic [AW-1:0] waddr;
    logic [23:0]   word_buf;
    logic [31:0]   full_word;
    logic          accept, mem_we;
    logic          gpio_meta, gpio_sync;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk           (clk),
        .rst           (rst),
        .uart_rxd      (uart_rxd),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_break (uart_rx_break),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data)
    );

    // The fourth byte is never buffered; it goes straight into the top lane.
    assign full_word = {uart_rx_data, word_buf};
    assign accept    = uart_rx_valid && !write_done;
    assign mem_we    = accept && (byte_idx == 2'd3) && (full_word != SENTINEL_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx   <= '0;
            waddr      <= '0;
            word_buf   <= '0;
            write_done <= 1'b0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0: word_buf[7:0]   <= uart_rx_data;
                2'd1: word_buf[15:8]  <= uart_rx_data;
                2'd2: word_buf[23:16] <= uart_rx_data;
                default: begin
                    if (full_word == SENTINEL_WORD) begin
                        write_done <= 1'b1;
                    end else begin
                        waddr <= waddr + AW'(1);
                        if (waddr == AW'(IMEM_DEPTH - 1)) write_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) imem[waddr] <= full_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_meta        <= 1'b0;
            gpio_sync        <= 1'b0;
            output_gpio_pins <= 1'b0;
        end else begin
            gpio_meta        <= input_gpio_pins;
            gpio_sync        <= gpio_meta;
            output_gpio_pins <= write_done ? gpio_sync : 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_boot_wrapper.sv
module tb_uart_boot_wrapper;

    localparam int unsigned CLK_HZ   = 160_000;
    localparam int unsigned BIT_RATE = 10_000;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned BIT      = CLK_HZ / BIT_RATE;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       input_gpio_pins;
    logic       output_gpio_pins;
    logic       write_done;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    int          valid_cnt = 0;
    int          break_cnt = 0;
    longint      cyc = 0;
    longint      last_valid_cyc = 0;
    longint      done_cyc = 0;
    bit          done_seen = 1'b0;

    uart_boot_wrapper #(
        .CLK_HZ     (CLK_HZ),
        .BIT_RATE   (BIT_RATE),
        .IMEM_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_rxd         (uart_rxd),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_break    (uart_rx_break),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .input_gpio_pins  (input_gpio_pins),
        .output_gpio_pins (output_gpio_pins),
        .write_done       (write_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid pulse must match the oldest byte sent.
    always @(negedge clk) begin
        if (!rst && uart_rx_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_valid: got byte 0x%02h, expected no frame", uart_rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (uart_rx_data !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", uart_rx_data, mon_exp);
                end
            end
        end
        if (!rst && uart_rx_break) break_cnt++;
        if (!rst && write_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic drive_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = frame[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        drive_bits({1'b1, b, 1'b0}, 10);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        done_seen = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 7;
        if (uart_rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b, expected 0", uart_rx_valid); end
        if (uart_rx_break !== 1'b0) begin tests_failed++; $display("FAIL rst_break: got %b, expected 0", uart_rx_break); end
        if (uart_rx_data !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got 0x%02h, expected 0x00", uart_rx_data); end
        if (write_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b, expected 0", write_done); end
        if (output_gpio_pins !== 1'b0) begin tests_failed++; $display("FAIL rst_gpio: got %b, expected 0", output_gpio_pins); end
        if (dut.byte_idx !== 2'd0) begin tests_failed++; $display("FAIL rst_byte_idx: got %0d, expected 0", dut.byte_idx); end
        if (dut.waddr !== 5'd0) begin tests_failed++; $display("FAIL rst_waddr: got %0d, expected 0", dut.waddr); end
        do_reset();
    endtask

    task automatic test_gpio_before_done();
        input_gpio_pins = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (output_gpio_pins !== 1'b0) begin tests_failed++; $display("FAIL gpio_held: got %b, expected 0", output_gpio_pins); end
        end
        input_gpio_pins = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int v0;
        v0 = valid_cnt;
        exp_q.push_back(8'h13);
        drive_bits({1'b1, 8'h13, 1'b0}, 9);
        tests_run += 2;
        if (uart_rx_data !== 8'h13) begin tests_failed++; $display("FAIL data_before_stop: got 0x%02h, expected 0x13", uart_rx_data); end
        if (valid_cnt !== v0) begin tests_failed++; $display("FAIL valid_early: got %0d pulses, expected %0d", valid_cnt, v0); end
        uart_rxd = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        tests_run++;
        if (valid_cnt !== v0 + 1) begin tests_failed++; $display("FAIL valid_once: got %0d pulses, expected %0d", valid_cnt - v0, 1); end
    endtask

    task automatic test_two_words();
        do_reset();
        send_word(32'hFE01_0113);
        send_word(32'h0081_2E23);
        repeat (4) @(negedge clk);
        tests_run += 4;
        if (dut.imem[0] !== 32'hFE01_0113) begin tests_failed++; $display("FAIL imem0: got 0x%08h, expected 0xfe010113", dut.imem[0]); end
        if (dut.imem[1] !== 32'h0081_2E23) begin tests_failed++; $display("FAIL imem1: got 0x%08h, expected 0x00812e23", dut.imem[1]); end
        if (write_done !== 1'b0) begin tests_failed++; $display("FAIL two_words_done: got %b, expected 0", write_done); end
        if (dut.waddr !== 5'd2) begin tests_failed++; $display("FAIL two_words_waddr: got %0d, expected 2", dut.waddr); end
    endtask

    task automatic test_break();
        int b0, v0;
        send_byte(8'hAA);
        b0 = break_cnt;
        v0 = valid_cnt;
        uart_rxd = 1'b0;
        repeat (10 * BIT) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        tests_run += 3;
        if (break_cnt !== b0 + 1) begin tests_failed++; $display("FAIL break_pulse: got %0d pulses, expected 1", break_cnt - b0); end
        if (valid_cnt !== v0) begin tests_failed++; $display("FAIL break_no_valid: got %0d pulses, expected 0", valid_cnt - v0); end
        if (dut.byte_idx !== 2'd1) begin tests_failed++; $display("FAIL break_byte_idx: got %0d, expected 1", dut.byte_idx); end
    endtask

    task automatic test_abort_and_reset();
        int v0;
        do_reset();
        send_word(32'hA5A5_0F0F);
        send_byte(8'h3C);
        send_byte(8'h7E);
        v0 = valid_cnt;
        drive_bits({1'b1, 8'h55, 1'b0}, 4);
        uart_rx_en = 1'b0;
        uart_rxd   = 1'b1;
        repeat (8 * BIT) @(negedge clk);
        uart_rx_en = 1'b1;
        repeat (BIT) @(negedge clk);
        tests_run += 3;
        if (valid_cnt !== v0) begin tests_failed++; $display("FAIL abort_no_valid: got %0d pulses, expected 0", valid_cnt - v0); end
        if (uart_rx_data !== 8'h7E) begin tests_failed++; $display("FAIL abort_data_kept: got 0x%02h, expected 0x7e", uart_rx_data); end
        if (dut.byte_idx !== 2'd2) begin tests_failed++; $display("FAIL abort_byte_idx: got %0d, expected 2", dut.byte_idx); end
        // Reset in the middle of a frame and of a word.
        drive_bits({1'b1, 8'h00, 1'b0}, 5);
        rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (BIT) @(negedge clk);
        tests_run += 3;
        if (valid_cnt !== v0) begin tests_failed++; $display("FAIL rst_mid_no_valid: got %0d pulses, expected 0", valid_cnt - v0); end
        if (dut.byte_idx !== 2'd0) begin tests_failed++; $display("FAIL rst_mid_byte_idx: got %0d, expected 0", dut.byte_idx); end
        if (dut.waddr !== 5'd0) begin tests_failed++; $display("FAIL rst_mid_waddr: got %0d, expected 0", dut.waddr); end
        send_word(32'hC0FF_EE42);
        repeat (4) @(negedge clk);
        tests_run += 2;
        if (dut.imem[0] !== 32'hC0FF_EE42) begin tests_failed++; $display("FAIL rst_rewrite_imem0: got 0x%08h, expected 0xc0ffee42", dut.imem[0]); end
        if (dut.waddr !== 5'd1) begin tests_failed++; $display("FAIL rst_rewrite_waddr: got %0d, expected 1", dut.waddr); end
    endtask

    task automatic test_full_load();
        logic [31:0] words [30];
        do_reset();
        for (int i = 0; i < 30; i++) begin
            words[i] = $urandom;
            if (words[i] == 32'hFFFF_FFFF) words[i] = 32'h1234_5678;
        end
        words[29] = 32'hFB9F_F06F;
        for (int i = 0; i < 30; i++) send_word(words[i]);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        tests_run++;
        if (write_done !== 1'b0) begin tests_failed++; $display("FAIL done_early: got %b, expected 0 after 123 bytes", write_done); end
        send_byte(8'hFF);
        repeat (2) @(negedge clk);
        tests_run += 3;
        if (write_done !== 1'b1) begin tests_failed++; $display("FAIL done_after_sentinel: got %b, expected 1", write_done); end
        if (!done_seen || done_cyc !== last_valid_cyc + 1) begin
            tests_failed++;
            $display("FAIL done_latency: got cycle %0d, expected %0d", done_cyc, last_valid_cyc + 1);
        end
        if (dut.waddr !== 5'd30) begin tests_failed++; $display("FAIL full_waddr: got %0d, expected 30", dut.waddr); end
        for (int i = 0; i < 30; i++) begin
            tests_run++;
            if (dut.imem[i] !== words[i]) begin tests_failed++; $display("FAIL full_imem[%0d]: got 0x%08h, expected 0x%08h", i, dut.imem[i], words[i]); end
        end
        send_word(32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        tests_run += 4;
        if (dut.waddr !== 5'd30) begin tests_failed++; $display("FAIL second_sentinel_waddr: got %0d, expected 30", dut.waddr); end
        if (dut.byte_idx !== 2'd0) begin tests_failed++; $display("FAIL second_sentinel_byte_idx: got %0d, expected 0", dut.byte_idx); end
        if (write_done !== 1'b1) begin tests_failed++; $display("FAIL done_sticky: got %b, expected 1", write_done); end
        if (uart_rx_data !== 8'hFF) begin tests_failed++; $display("FAIL data_after_done: got 0x%02h, expected 0xff", uart_rx_data); end
    endtask

    task automatic test_gpio_after_done();
        logic [1:0] vals;
        vals = 2'b01;
        for (int k = 0; k < 2; k++) begin
            input_gpio_pins = vals[k];
            repeat (2) @(negedge clk);
            tests_run++;
            if (output_gpio_pins !== ~vals[k]) begin tests_failed++; $display("FAIL gpio_not_yet: got %b, expected %b", output_gpio_pins, ~vals[k]); end
            @(negedge clk);
            tests_run++;
            if (output_gpio_pins !== vals[k]) begin tests_failed++; $display("FAIL gpio_3cyc: got %b, expected %b", output_gpio_pins, vals[k]); end
        end
    endtask

    task automatic test_mem_full();
        logic [7:0] idx;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            idx = 8'(i);
            send_word({idx, 8'h5A, ~idx, 8'hC3});
            if (i == 30) begin
                tests_run++;
                if (write_done !== 1'b0) begin tests_failed++; $display("FAIL mem_full_early: got %b, expected 0", write_done); end
            end
        end
        repeat (2) @(negedge clk);
        tests_run += 2;
        if (write_done !== 1'b1) begin tests_failed++; $display("FAIL mem_full_done: got %b, expected 1", write_done); end
        if (dut.imem[31] !== 32'h1F5A_E0C3) begin tests_failed++; $display("FAIL mem_full_imem31: got 0x%08h, expected 0x1f5ae0c3", dut.imem[31]); end
        send_word(32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        tests_run++;
        if (dut.imem[0] !== 32'h005A_FFC3) begin tests_failed++; $display("FAIL mem_full_no_wrap: got 0x%08h, expected 0x005affc3", dut.imem[0]); end
    endtask

    initial begin
        rst             = 1'b1;
        uart_rxd        = 1'b1;
        uart_rx_en      = 1'b1;
        input_gpio_pins = 1'b0;
        test_reset();
        test_gpio_before_done();
        test_single_byte();
        test_two_words();
        test_break();
        test_abort_and_reset();
        test_full_load();
        test_gpio_after_done();
        test_mem_full();
        repeat (BIT) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL frames_missing: got %0d unreceived, expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_boot_wrapper.md
# uart_boot_wrapper

Top-level boot wrapper for the automatic roof controller. It receives a program image over a 9600-baud 8N1 UART line and assembles it into 32-bit little-endian words in an on-chip instruction memory. It flags completion on `write_done` and then drives the roof GPIO output from the synchronized sensor input. It sits between the board pins and the controller core.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BIT_RATE`, 9600, UART baud; `CLKS_PER_BIT = CLK_HZ/BIT_RATE` (5208, integer division).
- `IMEM_DEPTH`, 32, instruction memory words; address width `$clog2(IMEM_DEPTH)`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state.
- `uart_rxd`  in  1  UART receive line, idle high, asynchronous to `clk`.
- `uart_rx_en`  in  1  receive enable; low forces the receiver to IDLE.
- `uart_rx_break`  out  1  one-cycle pulse when a BREAK frame is detected.
- `uart_rx_valid`  out  1  one-cycle pulse when a good frame completes.
- `uart_rx_data`  out  8  last received byte, held between frames.
- `input_gpio_pins`  in  1  roof sensor input, asynchronous.
- `output_gpio_pins`  out  1  roof actuator output.
- `write_done`  out  1  sticky; program load finished.

## Operation
Receiver:
- `uart_rxd` passes through a 2-flop synchronizer.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START on a synchronized falling edge while `uart_rx_en`=1.
- START: at half a bit period (`CLKS_PER_BIT/2`), a low line → DATA; a high line is a glitch → IDLE.
- DATA: sample every `CLKS_PER_BIT`, LSB first, 8 bits. At the bit-7 sample, load the assembled byte into `uart_rx_data`, then go to STOP.
- STOP: sample one bit period later.
  - Line high → `uart_rx_valid` pulses for one cycle.
  - Line low and byte == 0x00 → `uart_rx_break` pulses for one cycle.
  - Line low otherwise → framing error; no pulse.
  - All three cases return to IDLE.
- `uart_rx_en` low at any time aborts the frame → IDLE, with no pulse and no data update.

Loader:
- On each `uart_rx_valid` while `write_done`=0, shift the byte into the word buffer at lane `byte_idx` (byte 0 = bits 7:0), then increment the 2-bit `byte_idx`.
- On the 4th byte:
  - Word == 0xFFFF_FFFF → set `write_done`; the sentinel is not stored.
  - Otherwise → write the word to `imem[waddr]` and increment `waddr`.
  - If that write lands in the last address (`IMEM_DEPTH-1`), also set `write_done`.
- Break and framing-error frames do not advance `byte_idx`.
- After `write_done` is set, received bytes still update the UART outputs but are ignored by the loader.

GPIO:
- `input_gpio_pins` passes through a 2-flop synchronizer.
- While `write_done`=1, `output_gpio_pins` is registered from the synchronized input.
- Before `write_done`, `output_gpio_pins` is held 0.

## Timing
- Reset values: `uart_rx_break`=0, `uart_rx_valid`=0, `uart_rx_data`=0x00, `write_done`=0, `output_gpio_pins`=0, `byte_idx`=0, `waddr`=0, FSM=IDLE. Memory contents are not reset.
- `uart_rx_data` updates about 8.5 bit times (+2 sync cycles) after the start edge, i.e. before the stop bit.
- `uart_rx_valid` pulses about 9.5 bit times (+2 cycles) after the start edge.
- `write_done` rises on the cycle after the 4th-byte `uart_rx_valid`.
- GPIO latency is 3 clock cycles: 2 sync + 1 output register.
- `rst` asserted mid-frame or mid-word discards the partial byte/word; `waddr` returns to 0.
- A new start edge is accepted in the same cycle the FSM returns to IDLE.

## Structure
- Package `uart_boot_pkg`:
  - receiver state enum;
  - `SENTINEL_WORD` = 32'hFFFF_FFFF;
  - function computing `CLKS_PER_BIT`.
- Sub-module `uart_rx`: synchronizer, FSM, bit counter, baud counter; owns the `uart_rx_*` outputs.
- Loader, memory (`logic [31:0] imem[IMEM_DEPTH]`, one write port) and GPIO logic live in the top.

## Test plan
- Reset, then send byte 0x13 with `uart_rx_en`=1 → `uart_rx_data`=0x13 by the stop bit, and exactly one `uart_rx_valid` pulse.
- Send words 0xFE010113 and 0x00812E23 as bytes LSB first → `imem[0]`=0xFE010113, `imem[1]`=0x00812E23, `write_done`=0.
- Send 30 program words, then 0xFFFFFFFF twice → `write_done` rises after the 124th byte, `imem[29]`=0xFFB9FF06F's low 32 bits (0xFB9FF06F), `waddr`=30, and the second sentinel is ignored.
- With `write_done`=1, toggle `input_gpio_pins` 1→0 → `output_gpio_pins` follows 3 cycles later; before `write_done`, it stays 0.
- Hold `uart_rxd` low for 10 bit times with data 0x00 → `uart_rx_break` pulses, no `uart_rx_valid`, and `byte_idx` is unchanged.
- Deassert `uart_rx_en` mid-frame, or assert `rst` mid-word → no valid pulse; after `rst`, the next word is written at address 0.
